// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator: stage 1 decodes the immediate, stage 2 adds it to the PC.
// Elastic two-entry valid/ready pipeline with a pass-through sideband tag.
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [31:0]       instr_in,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [2:0]        imm_sel_in,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [XLEN-1:0]   imm_out,
    output logic [XLEN-1:0]   target_out,
    output logic              illegal_out,
    output logic [TAG_W-1:0]  tag_out
);

    localparam logic [2:0] SEL_I     = 3'd0;
    localparam logic [2:0] SEL_S     = 3'd1;
    localparam logic [2:0] SEL_B     = 3'd2;
    localparam logic [2:0] SEL_U     = 3'd3;
    localparam logic [2:0] SEL_J     = 3'd4;
    localparam logic [2:0] SEL_SHAMT = 3'd5;
    localparam logic [2:0] SEL_ZIMM  = 3'd6;

    // Decode
    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;

    // Start from a full sign fill (or zero) and overwrite the low bits, so
    // the same code works for XLEN=32 without zero-width replications.
    always_comb begin
        dec_imm = '0;
        dec_ill = 1'b0;
        case (imm_sel_in)
            SEL_I: begin
                dec_imm       = {XLEN{instr_in[31]}};
                dec_imm[11:0] = instr_in[31:20];
            end
            SEL_S: begin
                dec_imm       = {XLEN{instr_in[31]}};
                dec_imm[11:0] = {instr_in[31:25], instr_in[11:7]};
            end
            SEL_B: begin
                dec_imm       = {XLEN{instr_in[31]}};
                dec_imm[12:0] = {instr_in[31], instr_in[7], instr_in[30:25],
                                 instr_in[11:8], 1'b0};
            end
            SEL_U: begin
                dec_imm       = {XLEN{instr_in[31]}};
                dec_imm[31:0] = {instr_in[31:12], 12'b0};
            end
            SEL_J: begin
                dec_imm       = {XLEN{instr_in[31]}};
                dec_imm[20:0] = {instr_in[31], instr_in[19:12], instr_in[20],
                                 instr_in[30:21], 1'b0};
            end
            SEL_SHAMT: begin
                if (XLEN == 64) begin
                    dec_imm[5:0] = instr_in[25:20];
                end else begin
                    dec_imm[4:0] = instr_in[24:20];
                    dec_ill      = instr_in[25];
                end
            end
            SEL_ZIMM: begin
                dec_imm[4:0] = instr_in[19:15];
            end
            default: begin
                dec_imm = '0;
                dec_ill = 1'b1;
            end
        endcase
    end

    // Pipeline state
    logic              s1_valid_q, s1_valid_d;
    logic [XLEN-1:0]   s1_imm_q,   s1_imm_d;
    logic [XLEN-1:0]   s1_pc_q,    s1_pc_d;
    logic              s1_ill_q,   s1_ill_d;
    logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;

    logic              s2_valid_q, s2_valid_d;
    logic [XLEN-1:0]   s2_imm_q,   s2_imm_d;
    logic [XLEN-1:0]   s2_tgt_q,   s2_tgt_d;
    logic              s2_ill_q,   s2_ill_d;
    logic [TAG_W-1:0]  s2_tag_q,   s2_tag_d;

    logic s1_load, s2_load;

    // s1 may refill on the same edge that hands its entry to s2, so a full
    // pipe with ready_in high streams at one per cycle without bubbles.
    assign s2_load   = s1_valid_q && (!s2_valid_q || ready_in);
    assign s1_load   = valid_in && (!s1_valid_q || s2_load);
    assign ready_out = !s1_valid_q || !s2_valid_q || ready_in;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_imm_d   = s1_imm_q;
        s1_pc_d    = s1_pc_q;
        s1_ill_d   = s1_ill_q;
        s1_tag_d   = s1_tag_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_imm_d   = dec_imm;
            s1_pc_d    = pc_in;
            s1_ill_d   = dec_ill;
            s1_tag_d   = tag_in;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_imm_d   = s2_imm_q;
        s2_tgt_d   = s2_tgt_q;
        s2_ill_d   = s2_ill_q;
        s2_tag_d   = s2_tag_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_imm_d   = s1_imm_q;
            s2_tgt_d   = s1_pc_q + s1_imm_q;
            s2_ill_d   = s1_ill_q;
            s2_tag_d   = s1_tag_q;
        end else if (ready_in) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid_q <= 1'b0;
            s1_imm_q   <= '0;
            s1_pc_q    <= '0;
            s1_ill_q   <= 1'b0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_imm_q   <= '0;
            s2_tgt_q   <= '0;
            s2_ill_q   <= 1'b0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_imm_q   <= s1_imm_d;
            s1_pc_q    <= s1_pc_d;
            s1_ill_q   <= s1_ill_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_imm_q   <= s2_imm_d;
            s2_tgt_q   <= s2_tgt_d;
            s2_ill_q   <= s2_ill_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign valid_out   = s2_valid_q;
    assign imm_out     = s2_imm_q;
    assign target_out  = s2_tgt_q;
    assign illegal_out = s2_ill_q;
    assign tag_out     = s2_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: an RV64 and an RV32 instance share one stimulus stream.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  sel;
    logic [3:0]  tag;
    logic        ready_in;

    logic        r64, v64, ill64;
    logic [63:0] imm64, tgt64;
    logic [3:0]  tag64;
    logic        r32, v32, ill32;
    logic [31:0] imm32, tgt32;
    logic [3:0]  tag32;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .TAG_W(4)) u64 (
        .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .ready_out(r64),
        .instr_in(instr), .pc_in(pc), .imm_sel_in(sel), .tag_in(tag),
        .valid_out(v64), .ready_in(ready_in), .imm_out(imm64),
        .target_out(tgt64), .illegal_out(ill64), .tag_out(tag64)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(4)) u32 (
        .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .ready_out(r32),
        .instr_in(instr), .pc_in(pc[31:0]), .imm_sel_in(sel), .tag_in(tag),
        .valid_out(v32), .ready_in(ready_in), .imm_out(imm32),
        .target_out(tgt32), .illegal_out(ill32), .tag_out(tag32)
    );

    task automatic test_reset();
        rst_n = 1'b0; valid_in = 1'b0; instr = '0; pc = '0; sel = '0;
        tag = '0; ready_in = 1'b1;
        #12;
        checks++;
        if ({v64, ill64, imm64, tgt64, tag64} !== '0) begin
            failures++;
            $display("FAIL reset64 got v=%b ill=%b imm=%h tgt=%h tag=%h exp all 0",
                     v64, ill64, imm64, tgt64, tag64);
        end
        checks++;
        if ({v32, ill32, imm32, tgt32, tag32} !== '0) begin
            failures++;
            $display("FAIL reset32 got v=%b ill=%b imm=%h tgt=%h tag=%h exp all 0",
                     v32, ill32, imm32, tgt32, tag32);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({r64, r32} !== 2'b11) begin
            failures++;
            $display("FAIL reset_ready got %b%b exp 11", r64, r32);
        end
    endtask

    task automatic test_vec(input string nm, input logic [2:0] s, input logic [31:0] ins,
                            input logic [63:0] p, input logic [3:0] t,
                            input logic [63:0] e_imm64, input logic [63:0] e_tgt64,
                            input logic e_ill64, input logic [31:0] e_imm32,
                            input logic [31:0] e_tgt32, input logic e_ill32);
        @(negedge clk);
        valid_in = 1'b1; sel = s; instr = ins; pc = p; tag = t; ready_in = 1'b1;
        #1;
        checks++;
        if (r64 !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_out got %b exp 1", nm, r64);
        end
        @(posedge clk);
        #1 valid_in = 1'b0;
        @(negedge clk);
        checks++;
        if (v64 !== 1'b0) begin
            failures++;
            $display("FAIL %s early_valid got %b exp 0", nm, v64);
        end
        @(negedge clk);
        checks++;
        if ({v64, v32, tag64, tag32} !== {2'b11, t, t}) begin
            failures++;
            $display("FAIL %s valid_tag got v=%b%b tag=%h/%h exp v=11 tag=%h",
                     nm, v64, v32, tag64, tag32, t);
        end
        checks++;
        if ({imm64, tgt64, ill64} !== {e_imm64, e_tgt64, e_ill64}) begin
            failures++;
            $display("FAIL %s rv64 got imm=%h tgt=%h ill=%b exp imm=%h tgt=%h ill=%b",
                     nm, imm64, tgt64, ill64, e_imm64, e_tgt64, e_ill64);
        end
        checks++;
        if ({imm32, tgt32, ill32} !== {e_imm32, e_tgt32, e_ill32}) begin
            failures++;
            $display("FAIL %s rv32 got imm=%h tgt=%h ill=%b exp imm=%h tgt=%h ill=%b",
                     nm, imm32, tgt32, ill32, e_imm32, e_tgt32, e_ill32);
        end
    endtask

    task automatic test_decode();
        test_vec("I_neg", 3'd0, 32'hFFF00093, 64'h0, 4'h1,
                 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0,
                 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        test_vec("I_pos", 3'd0, 32'h7FF00093, 64'h100, 4'h2,
                 64'h7FF, 64'h8FF, 1'b0, 32'h7FF, 32'h8FF, 1'b0);
        test_vec("S", 3'd1, 32'h00112423, 64'h100, 4'h3,
                 64'h8, 64'h108, 1'b0, 32'h8, 32'h108, 1'b0);
        test_vec("B", 3'd2, 32'hFE000EE3, 64'h1000, 4'h4,
                 64'hFFFFFFFFFFFFFFFC, 64'hFFC, 1'b0, 32'hFFFFFFFC, 32'hFFC, 1'b0);
        test_vec("U", 3'd3, 32'h80000037, 64'h0, 4'h5,
                 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 1'b0,
                 32'h80000000, 32'h80000000, 1'b0);
        test_vec("J", 3'd4, 32'h0010006F, 64'h2000, 4'h6,
                 64'h800, 64'h2800, 1'b0, 32'h800, 32'h2800, 1'b0);
        test_vec("SHAMT", 3'd5, 32'h02001013, 64'h100, 4'h7,
                 64'h20, 64'h120, 1'b0, 32'h0, 32'h100, 1'b1);
        test_vec("ZIMM", 3'd6, 32'h000F8073, 64'h10, 4'h8,
                 64'h1F, 64'h2F, 1'b0, 32'h1F, 32'h2F, 1'b0);
        test_vec("SEL7", 3'd7, 32'hFFFFFFFF, 64'h40, 4'h9,
                 64'h0, 64'h40, 1'b1, 32'h0, 32'h40, 1'b1);
        test_vec("PC_WRAP", 3'd0, 32'h00400093, 64'hFFFFFFFFFFFFFFFE, 4'hA,
                 64'h4, 64'h2, 1'b0, 32'h4, 32'h2, 1'b0);
    endtask

    task automatic test_backpressure();
        int          idx = 0;
        int          rx = 0;
        int          occ = 0;
        int          in_acc, out_acc;
        logic        exp_rdy;
        logic        stall_prev = 1'b0;
        logic        saw_full = 1'b0;
        logic [63:0] s_imm, s_tgt;
        logic [3:0]  s_tag;
        logic [63:0] e_imm;
        repeat (3) @(negedge clk);
        for (int c = 0; c < 40 && rx < 6; c++) begin
            @(negedge clk);
            ready_in = !(c >= 3 && c <= 7);
            valid_in = (idx < 6);
            tag      = 4'(idx + 1);
            instr    = {12'((idx + 1) * 16), 20'h00013};
            pc       = 64'h1000;
            sel      = 3'd0;
            #1;
            exp_rdy = !(occ == 2 && !ready_in);
            if (!exp_rdy) saw_full = 1'b1;
            checks++;
            if (r64 !== exp_rdy) begin
                failures++;
                $display("FAIL bp_ready cyc=%0d got %b exp %b", c, r64, exp_rdy);
            end
            if (stall_prev) begin
                checks++;
                if ({imm64, tgt64, tag64, v64} !== {s_imm, s_tgt, s_tag, 1'b1}) begin
                    failures++;
                    $display("FAIL bp_stable cyc=%0d got imm=%h tag=%h v=%b exp imm=%h tag=%h v=1",
                             c, imm64, tag64, v64, s_imm, s_tag);
                end
            end
            if (rx > 0 && rx < 6) begin
                checks++;
                if (v64 !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_gap cyc=%0d valid_out got %b exp 1", c, v64);
                end
            end
            out_acc = (v64 && ready_in) ? 1 : 0;
            in_acc  = (valid_in && r64) ? 1 : 0;
            if (out_acc != 0) begin
                e_imm = 64'((rx + 1) * 16);
                checks++;
                if ({tag64, imm64, tgt64} !== {4'(rx + 1), e_imm, 64'h1000 + e_imm}) begin
                    failures++;
                    $display("FAIL bp_order item=%0d got tag=%h imm=%h tgt=%h exp tag=%h imm=%h tgt=%h",
                             rx, tag64, imm64, tgt64, 4'(rx + 1), e_imm, 64'h1000 + e_imm);
                end
                rx++;
            end
            if (in_acc != 0) idx++;
            occ = occ + in_acc - out_acc;
            stall_prev = v64 && !ready_in;
            s_imm = imm64; s_tgt = tgt64; s_tag = tag64;
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        checks++;
        if (rx != 6) begin
            failures++;
            $display("FAIL bp_count got %0d exp 6", rx);
        end
        checks++;
        if (saw_full !== 1'b1) begin
            failures++;
            $display("FAIL bp_full got %b exp 1", saw_full);
        end
    endtask

    task automatic test_reset_mid();
        repeat (3) @(negedge clk);
        ready_in = 1'b0; valid_in = 1'b1; sel = 3'd0; pc = 64'h3000;
        tag = 4'hA; instr = 32'h00100093;
        @(posedge clk);
        @(negedge clk);
        tag = 4'hB; instr = 32'h00200093;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        #1;
        checks++;
        if ({v64, r64, tag64} !== {1'b1, 1'b0, 4'hA}) begin
            failures++;
            $display("FAIL rst_full got v=%b rdy=%b tag=%h exp v=1 rdy=0 tag=a", v64, r64, tag64);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({v64, ill64, imm64, tgt64, tag64, v32} !== '0) begin
            failures++;
            $display("FAIL rst_async got v=%b imm=%h tgt=%h tag=%h v32=%b exp all 0",
                     v64, imm64, tgt64, tag64, v32);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({r64, r32} !== 2'b11) begin
            failures++;
            $display("FAIL rst_ready got %b%b exp 11", r64, r32);
        end
        ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({v64, v32, tag64} !== 6'b0) begin
                failures++;
                $display("FAIL rst_stale cyc=%0d got v=%b%b tag=%h exp v=00 tag=0", i, v64, v32, tag64);
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
